bitlet_acc_ctrl: RTL and testbench

Job-level sequencer in front of the Bitlet 24-channel shift-accumulator. Accepts a job descriptor giving the vector count and clears the accumulator with a one-cycle flush. It then streams the job's selected-activation vectors into the accumulator and waits until every accumulation burst has drained. The final accumulated sum is returned on a valid/ready result port. Sits between the activation-select stage and the PE output/writeback logic.

---
 rtl/bitlet_acc_ctrl.sv | 143 ++++++++++++++
 tb/tb_bitlet_acc_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitlet_acc_ctrl.sv
// ---------------------------------------------------------------------------
// bitlet_acc_ctrl
//   Job-level sequencer for the Bitlet 24-channel shift-accumulator.
//   Takes a job descriptor (vector count). Clears the accumulator with a
//   one-cycle flush. Streams the job's activation vectors into the
//   accumulator. Waits until every accumulation burst has reported back,
//   then presents the final sum on a valid/ready result port.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   job_vld/job_rdy     job descriptor handshake; job_len = vectors in job
//   vec_vld/vec_rdy     input vector handshake; vec_data = N_CH x WID_FIX
//   acc_flush           one-cycle accumulator clear
//   acc_in_vld/_vec     vector stream into the accumulator
//   acc_out_vld/acc_out accumulator burst-done pulse and running sum
//   res_vld/res_rdy     result handshake; res_data = final job sum
//   busy                controller is not idle
// ---------------------------------------------------------------------------
module bitlet_acc_ctrl #(
    parameter int N_CH    = 24,
    parameter int WID_FIX = 16,
    parameter int WID_ACC = 32,
    parameter int LEN_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    job_vld,
    output logic                    job_rdy,
    input  logic [LEN_W-1:0]        job_len,
    input  logic                    vec_vld,
    output logic                    vec_rdy,
    input  logic [N_CH*WID_FIX-1:0] vec_data,
    output logic                    acc_flush,
    output logic                    acc_in_vld,
    output logic [N_CH*WID_FIX-1:0] acc_in_vec,
    input  logic                    acc_out_vld,
    input  logic [WID_ACC-1:0]      acc_out,
    output logic                    res_vld,
    input  logic                    res_rdy,
    output logic [WID_ACC-1:0]      res_data,
    output logic                    busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FLUSH  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [2:0]         state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   vec_cnt;
    logic [LEN_W-1:0]   burst_cnt;
    logic [LEN_W-1:0]   done_cnt;
    logic               prev_vld;   // acc_in_vld of the previous cycle
    logic [WID_ACC-1:0] res_q;

    logic burst_start;
    logic last_vec;
    logic final_pulse;

    // Outputs are pure decodes of state so nothing glitches between jobs.
    assign job_rdy    = (state == ST_IDLE);
    assign vec_rdy    = (state == ST_STREAM);
    assign acc_flush  = (state == ST_FLUSH);
    assign res_vld    = (state == ST_HOLD);
    assign busy       = (state != ST_IDLE);
    assign acc_in_vld = vec_rdy & vec_vld;
    assign acc_in_vec = vec_data;
    assign res_data   = res_q;

    // A rising edge of acc_in_vld opens a new accumulator burst; the
    // accumulator answers each burst with exactly one acc_out_vld.
    assign burst_start = acc_in_vld & ~prev_vld;
    assign last_vec    = (vec_cnt == len_q - ONE);
    // The final burst has been counted by the time we reach DRAIN, so the
    // pulse that brings done_cnt up to burst_cnt carries the full job sum.
    assign final_pulse = (done_cnt + ONE == burst_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            vec_cnt   <= '0;
            burst_cnt <= '0;
            done_cnt  <= '0;
            prev_vld  <= 1'b0;
            res_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (job_vld) begin
                        len_q <= job_len;
                        if (job_len == '0) begin
                            // Empty job: no accumulator traffic, sum is zero.
                            res_q <= '0;
                            state <= ST_HOLD;
                        end else begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    vec_cnt   <= '0;
                    burst_cnt <= '0;
                    done_cnt  <= '0;
                    prev_vld  <= 1'b0;
                    state     <= ST_STREAM;
                end
                ST_STREAM: begin
                    prev_vld <= acc_in_vld;
                    if (burst_start)
                        burst_cnt <= burst_cnt + ONE;
                    if (acc_out_vld)
                        done_cnt <= done_cnt + ONE;
                    if (vec_vld) begin
                        vec_cnt <= vec_cnt + ONE;
                        if (last_vec)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    prev_vld <= 1'b0;
                    if (acc_out_vld) begin
                        done_cnt <= done_cnt + ONE;
                        if (final_pulse) begin
                            res_q <= acc_out;
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (res_rdy)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitlet_acc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bitlet_acc_ctrl
//   Directed bench for bitlet_acc_ctrl. A small behavioural accumulator
//   sums all channels of each accepted vector (signed), clears on acc_flush,
//   and pulses acc_out_vld two cycles after each burst ends. Its sum is
//   deliberately not cleared by rst_n so stale residue must be removed by
//   the controller's flush. Inputs are driven just after the falling edge,
//   outputs are checked away from the rising edge.
// ---------------------------------------------------------------------------
module tb_bitlet_acc_ctrl;

    localparam int N_CH    = 24;
    localparam int WID_FIX = 16;
    localparam int WID_ACC = 32;
    localparam int LEN_W   = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    job_vld = 1'b0;
    logic                    job_rdy;
    logic [LEN_W-1:0]        job_len = '0;
    logic                    vec_vld = 1'b0;
    logic                    vec_rdy;
    logic [N_CH*WID_FIX-1:0] vec_data = '0;
    logic                    acc_flush;
    logic                    acc_in_vld;
    logic [N_CH*WID_FIX-1:0] acc_in_vec;
    logic                    acc_out_vld;
    logic [WID_ACC-1:0]      acc_out;
    logic                    res_vld;
    logic                    res_rdy = 1'b0;
    logic [WID_ACC-1:0]      res_data;
    logic                    busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bitlet_acc_ctrl #(
        .N_CH(N_CH), .WID_FIX(WID_FIX), .WID_ACC(WID_ACC), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .job_vld(job_vld), .job_rdy(job_rdy), .job_len(job_len),
        .vec_vld(vec_vld), .vec_rdy(vec_rdy), .vec_data(vec_data),
        .acc_flush(acc_flush), .acc_in_vld(acc_in_vld), .acc_in_vec(acc_in_vec),
        .acc_out_vld(acc_out_vld), .acc_out(acc_out),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data),
        .busy(busy)
    );

    // ---------------- accumulator model + event counters ----------------
    logic [WID_ACC-1:0] m_sum   = '0;
    logic               m_in_d  = 1'b0;
    logic               m_pulse = 1'b0;
    int n_flush  = 0;
    int n_invld  = 0;
    int n_outvld = 0;

    function automatic logic [WID_ACC-1:0] vsum(input logic [N_CH*WID_FIX-1:0] v);
        logic signed [WID_ACC-1:0] s;
        logic signed [WID_FIX-1:0] e;
        s = '0;
        for (int i = 0; i < N_CH; i++) begin
            e = v[i*WID_FIX +: WID_FIX];
            s = s + WID_ACC'(e);
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (acc_flush)       m_sum <= '0;
        else if (acc_in_vld) m_sum <= m_sum + vsum(acc_in_vec);
        m_in_d  <= acc_in_vld;
        m_pulse <= m_in_d & ~acc_in_vld;
        n_flush  <= n_flush  + int'(acc_flush);
        n_invld  <= n_invld  + int'(acc_in_vld);
        n_outvld <= n_outvld + int'(m_pulse);
    end

    assign acc_out_vld = m_pulse;
    assign acc_out     = m_sum;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic accept(input int len);
        job_vld = 1'b1;
        job_len = LEN_W'(len);
        #1 chk("job_rdy_idle", job_rdy, 1);
        cyc();
        job_vld = 1'b0;
    endtask

    task automatic flush_cyc();
        #1;
        chk("flush_pulse", acc_flush, 1);
        chk("flush_vec_rdy", vec_rdy, 0);
        chk("flush_job_rdy", job_rdy, 0);
        chk("flush_busy", busy, 1);
        cyc();
    endtask

    task automatic send(input logic v, input int val);
        logic signed [WID_FIX-1:0] e;
        e = WID_FIX'(val);
        vec_vld  = v;
        vec_data = {N_CH{e}};
        #1;
        chk("stream_vec_rdy", vec_rdy, 1);
        chk("stream_in_vld", acc_in_vld, 32'(v));
        chk("stream_no_res", res_vld, 0);
        cyc();
        vec_vld = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int max);
        int n = 0;
        while (!res_vld && n < max) begin
            cyc();
            n++;
        end
        chk(tag, res_vld, 1);
    endtask

    task automatic take();
        res_rdy = 1'b1;
        cyc();
        res_rdy = 1'b0;
        #1;
        chk("post_take_res_vld", res_vld, 0);
        chk("post_take_job_rdy", job_rdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int f0, i0, o0;

        // Reset state
        repeat (3) cyc();
        chk("rst_job_rdy", job_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_vld", res_vld, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_flush", acc_flush, 0);
        chk("rst_vec_rdy", vec_rdy, 0);
        rst_n = 1'b1;
        cyc();

        // Contiguous job: 4 vectors of all-ones -> 96
        f0 = n_flush; i0 = n_invld; o0 = n_outvld;
        accept(4);
        flush_cyc();
        for (int k = 0; k < 4; k++) send(1'b1, 1);
        vec_vld = 1'b1;          // extra vector offered in DRAIN must be refused
        #1;
        chk("drain_vec_rdy", vec_rdy, 0);
        chk("drain_in_vld", acc_in_vld, 0);
        chk("drain_job_rdy", job_rdy, 0);
        vec_vld = 1'b0;
        wait_res("contig_res_timeout", 20);
        chk("contig_res_data", res_data, 96);
        chk("contig_flushes", n_flush - f0, 1);
        chk("contig_in_cycles", n_invld - i0, 4);
        chk("contig_pulses", n_outvld - o0, 1);
        take();

        // Bubbled job: 1,1,0,1,0,0,1,1 with values 1..5 -> 24*15 = 360
        o0 = n_outvld;
        accept(5);
        flush_cyc();
        send(1'b1, 1); send(1'b1, 2); send(1'b0, 0); send(1'b1, 3);
        send(1'b0, 0); send(1'b0, 0); send(1'b1, 4); send(1'b1, 5);
        wait_res("bubble_res_timeout", 20);
        chk("bubble_pulses_at_res", n_outvld - o0, 3);
        chk("bubble_res_data", res_data, 360);
        take();

        // Zero-length job
        f0 = n_flush; i0 = n_invld;
        accept(0);
        #1;
        chk("zero_res_vld", res_vld, 1);
        chk("zero_res_data", res_data, 0);
        chk("zero_no_flush", n_flush - f0, 0);
        chk("zero_no_in", n_invld - i0, 0);
        take();

        // Back-pressure: len=1 value 7 -> 168, held 10 cycles with job_vld up
        accept(1);
        flush_cyc();
        send(1'b1, 7);
        wait_res("bp_res_timeout", 20);
        job_vld = 1'b1;
        job_len = 8'd2;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp_res_vld", res_vld, 1);
            chk("bp_res_data", res_data, 168);
            chk("bp_job_rdy", job_rdy, 0);
            cyc();
        end
        res_rdy = 1'b1;
        #1 chk("bp_no_flush_at_hs", acc_flush, 0);
        cyc();
        res_rdy = 1'b0;
        // job_vld still high: accepted only now, in IDLE
        #1 chk("bp_job_rdy_after", job_rdy, 1);
        cyc();
        job_vld = 1'b0;
        flush_cyc();
        send(1'b1, 1); send(1'b1, 1);
        wait_res("bp_job2_timeout", 20);
        chk("bp_job2_data", res_data, 48);
        take();

        // Back-to-back: A len3 of 1 -> 72, then B len2 of -1 -> -48
        accept(3);
        flush_cyc();
        for (int k = 0; k < 3; k++) send(1'b1, 1);
        wait_res("b2b_a_timeout", 20);
        chk("b2b_a_data", res_data, 72);
        take();
        accept(2);
        flush_cyc();
        send(1'b1, -1); send(1'b1, -1);
        wait_res("b2b_b_timeout", 20);
        chk("b2b_b_data", res_data, 32'hFFFF_FFD0);
        take();

        // Reset mid-STREAM after 2 of 6 vectors, then len=1 value 3 -> 72
        accept(6);
        flush_cyc();
        send(1'b1, 5); send(1'b1, 5);
        vec_vld = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_job_rdy", job_rdy, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_vec_rdy", vec_rdy, 0);
        chk("midrst_in_vld", acc_in_vld, 0);
        chk("midrst_flush", acc_flush, 0);
        chk("midrst_res_vld", res_vld, 0);
        chk("midrst_res_data", res_data, 0);
        cyc();
        vec_vld = 1'b0;
        rst_n = 1'b1;
        cyc();
        accept(1);
        flush_cyc();
        send(1'b1, 3);
        wait_res("midrst_res_timeout", 20);
        chk("midrst_next_data", res_data, 72);
        take();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
